memory_io_bank: RTL and testbench

- Parametrised memory subsystem for the CDEC datapath core.
- One RAM array with two ports on a single clock:
  - core port: read/write.
  - monitor/programmer port: RAM read/write, IO region read-only.
- Top of the address space holds NIO memory-mapped IO channels and one status register.
- Input ports are synchronised and watched for changes; a sticky change-flag register drives an interrupt line.

---
 rtl/memory_io_bank.sv | 187 ++++++++++++++++++
 tb/tb_memory_io_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memory_io_bank.sv
// memory_io_bank: dual-port RAM with memory-mapped IO channels and a
// sticky change-flag status register at the top of the address space.

// Per-channel IO slice: input synchroniser, change detector with a sticky
// flag, and the output register for this channel.
module memory_io_chan #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] iport_i,
  input  logic          owr_i,
  input  logic [DW-1:0] wd_i,
  input  logic          clr_i,
  output logic [DW-1:0] sync_o,
  output logic [DW-1:0] oport_o,
  output logic          flag_o
);
  logic [SYNC_STAGES-1:0][DW-1:0] sync_q;
  logic [DW-1:0]                  prev_q;
  logic [DW-1:0]                  oport_q;
  logic                           flag_q, flag_d;
  logic                           chg;

  assign sync_o  = sync_q[SYNC_STAGES-1];
  assign oport_o = oport_q;
  assign flag_o  = flag_q;
  assign chg     = (sync_q[SYNC_STAGES-1] != prev_q);

  // A new change beats a simultaneous write-1-to-clear.
  always_comb begin
    flag_d = (flag_q & ~clr_i) | chg;
  end

  // Synchroniser shift, previous-value tracking, flag and output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      flag_q  <= 1'b0;
      oport_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], iport_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      flag_q  <= flag_d;
      if (owr_i) oport_q <= wd_i;
    end
  end
endmodule

module memory_io_bank #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int NIO         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     MA,
  input  logic [DW-1:0]     WD,
  output logic [DW-1:0]     RD,
  input  logic [NIO*DW-1:0] iport,
  output logic [NIO*DW-1:0] oport,
  input  logic              prg_we,
  input  logic [AW-1:0]     prg_MA,
  input  logic [DW-1:0]     prg_WD,
  output logic [DW-1:0]     prg_RD,
  output logic              irq
);
  localparam int RAM_N = (2 ** AW) - NIO - 1;
  localparam int IW    = (NIO > 1) ? $clog2(NIO) : 1;
  localparam logic [AW-1:0] TOP_A     = {AW{1'b1}};
  localparam logic [AW-1:0] IO_BASE_A = TOP_A - AW'(NIO);

  typedef enum logic [1:0] {SEL_RAM, SEL_IO, SEL_ST} sel_e;

  logic [DW-1:0] mem [0:RAM_N-1];

  // Address decode for both ports.
  logic          c_ram, c_st, c_io, p_ram, p_st, p_io;
  logic [AW-1:0] c_off, p_off;
  logic [IW-1:0] c_idx, p_idx;
  sel_e          c_sel_d, p_sel_d;

  assign c_ram = (MA < IO_BASE_A);
  assign c_st  = (MA == TOP_A);
  assign c_io  = !c_ram && !c_st;
  assign p_ram = (prg_MA < IO_BASE_A);
  assign p_st  = (prg_MA == TOP_A);
  assign p_io  = !p_ram && !p_st;
  assign c_off = MA - IO_BASE_A;
  assign p_off = prg_MA - IO_BASE_A;
  assign c_idx = c_off[IW-1:0];
  assign p_idx = p_off[IW-1:0];

  // Region select that travels with each read address.
  always_comb begin
    c_sel_d = c_ram ? SEL_RAM : (c_io ? SEL_IO : SEL_ST);
    p_sel_d = p_ram ? SEL_RAM : (p_io ? SEL_IO : SEL_ST);
  end

  // Write qualifiers; on a same-address collision the core write wins.
  logic c_ram_wr, p_ram_wr, c_io_wr, c_st_wr;
  assign c_ram_wr = we && c_ram;
  assign p_ram_wr = prg_we && p_ram && !(c_ram_wr && (MA == prg_MA));
  assign c_io_wr  = we && c_io;
  assign c_st_wr  = we && c_st;

  // RAM array: two write ports, read-first registered reads, no reset.
  logic [DW-1:0] ram_c_q, ram_p_q;
  always_ff @(posedge clock) begin
    if (c_ram_wr) mem[MA]     <= WD;
    if (p_ram_wr) mem[prg_MA] <= prg_WD;
    ram_c_q <= mem[MA];
    ram_p_q <= mem[prg_MA];
  end

  // IO channels.
  logic [NIO-1:0][DW-1:0] sync_w;
  logic [NIO-1:0]         flag_w;

  for (genvar k = 0; k < NIO; k++) begin : g_chan
    memory_io_chan #(.DW(DW), .SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clock   (clock),
      .reset   (reset),
      .iport_i (iport[k*DW +: DW]),
      .owr_i   (c_io_wr && (c_idx == IW'(k))),
      .wd_i    (WD),
      .clr_i   (c_st_wr && WD[k]),
      .sync_o  (sync_w[k]),
      .oport_o (oport[k*DW +: DW]),
      .flag_o  (flag_w[k])
    );
  end

  logic [DW-1:0] status_w;
  assign status_w = DW'(flag_w);

  // Registered read select/index; vld squashes reads cut off by reset.
  sel_e          c_sel_q, p_sel_q;
  logic [IW-1:0] c_idx_q, p_idx_q;
  logic          c_vld_q, p_vld_q;
  logic          irq_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_sel_q <= SEL_RAM;
      p_sel_q <= SEL_RAM;
      c_idx_q <= '0;
      p_idx_q <= '0;
      c_vld_q <= 1'b0;
      p_vld_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      c_sel_q <= c_sel_d;
      p_sel_q <= p_sel_d;
      c_idx_q <= c_idx;
      p_idx_q <= p_idx;
      c_vld_q <= 1'b1;
      p_vld_q <= 1'b1;
      irq_q   <= |flag_w;
    end
  end

  assign irq = irq_q;

  // Output mux driven by the registered select so data matches its source.
  always_comb begin
    RD     = '0;
    prg_RD = '0;
    if (c_vld_q) begin
      case (c_sel_q)
        SEL_RAM: RD = ram_c_q;
        SEL_IO:  RD = sync_w[c_idx_q];
        default: RD = status_w;
      endcase
    end
    if (p_vld_q) begin
      case (p_sel_q)
        SEL_RAM: prg_RD = ram_p_q;
        SEL_IO:  prg_RD = sync_w[p_idx_q];
        default: prg_RD = status_w;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_io_bank.sv
// Scoreboard bench for memory_io_bank with default parameters.
module tb_memory_io_bank;
  logic        clock = 1'b0;
  logic        reset;
  logic        we, prg_we;
  logic [7:0]  MA, WD, prg_MA, prg_WD;
  logic [7:0]  RD, prg_RD;
  logic [31:0] iport, oport;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic       chk_core = 1'b0, chk_prg = 1'b0;
  logic [7:0] q_core[$];
  logic [7:0] q_prg[$];

  memory_io_bank #(.DW(8), .AW(8), .NIO(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .we(we), .MA(MA), .WD(WD), .RD(RD),
    .iport(iport), .oport(oport), .prg_we(prg_we), .prg_MA(prg_MA),
    .prg_WD(prg_WD), .prg_RD(prg_RD), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read issued at a posedge is checked at the following negedge.
  initial begin
    logic pc, pp;
    logic [7:0] e;
    forever begin
      @(posedge clock);
      pc = chk_core;
      pp = chk_prg;
      @(negedge clock);
      if (pc) begin
        if (q_core.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_RD: got %h with empty expectation queue", RD);
        end else begin
          e = q_core.pop_front();
          check("core_RD", {24'h0, RD}, {24'h0, e});
        end
      end
      if (pp) begin
        if (q_prg.size() == 0) begin
          checks++; errors++;
          $display("FAIL prg_RD: got %h with empty expectation queue", prg_RD);
        end else begin
          e = q_prg.pop_front();
          check("prg_RD", {24'h0, prg_RD}, {24'h0, e});
        end
      end
    end
  end

  task automatic step(input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic cc, input logic [7:0] ce,
                      input logic pw, input logic [7:0] pa, input logic [7:0] pd,
                      input logic pc, input logic [7:0] pe);
    we = cw; MA = ca; WD = cd; chk_core = cc;
    prg_we = pw; prg_MA = pa; prg_WD = pd; chk_prg = pc;
    if (cc) q_core.push_back(ce);
    if (pc) q_prg.push_back(pe);
    @(negedge clock);
    we = 1'b0; prg_we = 1'b0; chk_core = 1'b0; chk_prg = 1'b0;
  endtask

  task automatic cwr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0);
  endtask
  task automatic crd(input logic [7:0] a, input logic [7:0] e);
    step(1'b0, a, 8'h0, 1'b1, e, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0);
  endtask
  task automatic pwr(input logic [7:0] a, input logic [7:0] d);
    step(1'b0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b1, a, d, 1'b0, 8'h0);
  endtask
  task automatic idle();
    step(1'b0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; prg_we = 1'b0;
    MA = 8'h0; WD = 8'h0; prg_MA = 8'h0; prg_WD = 8'h0; iport = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_RD", {24'h0, RD}, 32'h0);
    check("rst_prg_RD", {24'h0, prg_RD}, 32'h0);
    check("rst_oport", oport, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    // RAM round trip
    cwr(8'h10, 8'h5A);
    step(1'b0, 8'h10, 8'h0, 1'b1, 8'h5A, 1'b0, 8'h10, 8'h0, 1'b1, 8'h5A);
    pwr(8'hFA, 8'h33);
    crd(8'hFA, 8'h33);

    // Collision: core wins; read-first on same and cross port
    step(1'b1, 8'h20, 8'h11, 1'b0, 8'h0, 1'b1, 8'h20, 8'h22, 1'b0, 8'h0);
    step(1'b0, 8'h20, 8'h0, 1'b1, 8'h11, 1'b0, 8'h20, 8'h0, 1'b1, 8'h11);
    step(1'b1, 8'h20, 8'h44, 1'b1, 8'h11, 1'b0, 8'h20, 8'h0, 1'b1, 8'h11);
    crd(8'h20, 8'h44);

    // IO output channel 2; monitor write ignored; oport not readable
    cwr(8'hFD, 8'hC3);
    check("oport_wr", oport, 32'h00C3_0000);
    pwr(8'hFD, 8'hFF);
    check("oport_prg_ignored", oport, 32'h00C3_0000);
    crd(8'hFD, 8'h00);

    // IO input change on channel 0
    iport = 32'h0000_0081;
    idle();
    idle();
    check("irq_before_flag", {31'h0, irq}, 32'h0);
    crd(8'hFB, 8'h81);
    check("irq_lags_flag", {31'h0, irq}, 32'h0);
    crd(8'hFF, 8'h01);
    check("irq_set", {31'h0, irq}, 32'h1);
    cwr(8'hFF, 8'h01);
    check("irq_clear_lag", {31'h0, irq}, 32'h1);
    crd(8'hFF, 8'h00);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Set beats clear on the same cycle
    iport = 32'h0000_007E;
    idle(); idle(); idle();
    iport = 32'h0000_0055;
    idle(); idle();
    cwr(8'hFF, 8'h01);
    crd(8'hFF, 8'h01);
    check("irq_set_wins", {31'h0, irq}, 32'h1);

    // Build flags = 0x05, then reset with a read outstanding
    cwr(8'hFF, 8'h01);
    iport = 32'h00AA_0001;
    idle(); idle(); idle();
    crd(8'hFF, 8'h05);
    check("irq_pre_reset", {31'h0, irq}, 32'h1);
    step(1'b0, 8'h10, 8'h0, 1'b0, 8'h0, 1'b0, 8'hFA, 8'h0, 1'b0, 8'h0);
    check("pre_reset_RD", {24'h0, RD}, 32'h5A);
    MA = 8'h20; prg_MA = 8'h20;
    #2 reset = 1'b1;
    #1;
    check("async_rst_RD", {24'h0, RD}, 32'h0);
    check("async_rst_prg_RD", {24'h0, prg_RD}, 32'h0);
    check("async_rst_oport", oport, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    iport = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_release_RD", {24'h0, RD}, 32'h0);
    @(negedge clock);
    crd(8'h10, 8'h5A);
    step(1'b0, 8'h20, 8'h0, 1'b0, 8'h0, 1'b0, 8'hFA, 8'h0, 1'b1, 8'h33);
    crd(8'hFF, 8'h00);
    check("post_reset_oport", oport, 32'h0);
    idle();
    idle();

    checks++;
    if (q_core.size() != 0 || q_prg.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", q_core.size(), q_prg.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
